// File: rtl/hazard_scoreboard.sv
// Multi-entry scoreboard for in-flight long-latency register writes.
// Raises a same-cycle stall/bubble on RAW, WAW or full hazards.
module hazard_scoreboard #(
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_SRC     = 3,
  parameter int NUM_ENTRIES = 4,
  parameter int LAT_WIDTH   = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]               issue_dest_i,
  input  logic [LAT_WIDTH-1:0]                issue_latency_i,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]       src_addr_i,
  output logic                                stall_pipeline_o,
  output logic                                hazard_detector_invalidate_o,
  output logic                                full_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]    pending_count_o,
  output logic [CNT_WIDTH-1:0]                stall_count_o
);

  localparam int PCW = $clog2(NUM_ENTRIES+1);

  logic [NUM_ENTRIES-1:0] valid_r;
  logic [ADDR_WIDTH-1:0]  dest_r  [NUM_ENTRIES];
  logic [LAT_WIDTH-1:0]   count_r [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]   stall_count_r;

  logic                   raw_hit_s;
  logic                   waw_hit_s;
  logic                   full_s;
  logic                   tracked_s;
  logic                   stall_s;
  logic                   accept_s;
  logic                   alloc_en_s;
  logic [NUM_ENTRIES-1:0] free_s;
  logic [NUM_ENTRIES-1:0] alloc_oh_s;
  logic [PCW-1:0]         pending_s;

  // Hazard detection against the current scoreboard contents
  always_comb begin
    raw_hit_s = 1'b0;
    waw_hit_s = 1'b0;
    pending_s = '0;
    tracked_s = (issue_latency_i != '0);
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      pending_s = pending_s + PCW'(valid_r[e]);
      waw_hit_s = waw_hit_s | (valid_r[e] & tracked_s & (dest_r[e] == issue_dest_i));
      for (int k = 0; k < NUM_SRC; k++) begin
        raw_hit_s = raw_hit_s | (valid_r[e] & src_valid_i[k] &
                                 (dest_r[e] == src_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
    full_s     = &valid_r;
    stall_s    = issue_valid_i & ~flush_i & (raw_hit_s | waw_hit_s | (tracked_s & full_s));
    accept_s   = issue_valid_i & ~stall_s & ~flush_i;
    alloc_en_s = accept_s & tracked_s;
    // Lowest free entry as a one-hot isolate of the free mask
    free_s     = ~valid_r;
    alloc_oh_s = free_s & (~free_s + NUM_ENTRIES'(1));
  end

  // Entry allocation, aging and flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        dest_r[e]  <= '0;
        count_r[e] <= '0;
      end
    end else if (flush_i) begin
      valid_r <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (alloc_en_s && alloc_oh_s[e]) begin
          valid_r[e] <= 1'b1;
          dest_r[e]  <= issue_dest_i;
          count_r[e] <= issue_latency_i;
        end else if (valid_r[e]) begin
          if (count_r[e] == LAT_WIDTH'(1)) begin
            valid_r[e] <= 1'b0;
          end else begin
            count_r[e] <= count_r[e] - LAT_WIDTH'(1);
          end
        end else begin
          valid_r[e] <= 1'b0;
        end
      end
    end
  end

  // Saturating stall performance counter, kept across flushes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_count_r <= '0;
    end else if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_WIDTH'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_pipeline_o             = stall_s;
  assign hazard_detector_invalidate_o = stall_s;
  assign full_o                       = full_s;
  assign pending_count_o              = pending_s;
  assign stall_count_o                = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + randomized bench for hazard_scoreboard against a per-register
// ready-time reference model.
module tb_hazard_scoreboard;
  localparam int AW = 4;
  localparam int NS = 3;
  localparam int NE = 4;
  localparam int LW = 3;
  localparam int CW = 6;
  localparam int PW = $clog2(NE+1);
  localparam int SC_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              issue_valid;
  logic [AW-1:0]     issue_dest;
  logic [LW-1:0]     issue_latency;
  logic [NS-1:0]     src_valid;
  logic [NS*AW-1:0]  src_addr;
  logic              stall_pipeline;
  logic              invalidate;
  logic              full;
  logic [PW-1:0]     pending_count;
  logic [CW-1:0]     stall_count;

  hazard_scoreboard #(
    .ADDR_WIDTH(AW), .NUM_SRC(NS), .NUM_ENTRIES(NE), .LAT_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_dest_i(issue_dest), .issue_latency_i(issue_latency),
    .src_valid_i(src_valid), .src_addr_i(src_addr),
    .stall_pipeline_o(stall_pipeline), .hazard_detector_invalidate_o(invalidate),
    .full_o(full), .pending_count_o(pending_count), .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a register is pending while cyc < ready_at[reg]
  longint cyc;
  longint ready_at [1 << AW];
  int     sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < (1 << AW); r++) ready_at[r] = 0;
    sc = 0;
  endtask

  task automatic set_in(input bit iv, input int dest, input int lat, input bit [NS-1:0] sv,
                        input int s0, input int s1, input int s2, input bit fl);
    issue_valid   = iv;
    issue_dest    = AW'(dest);
    issue_latency = LW'(lat);
    src_valid     = sv;
    src_addr      = {AW'(s2), AW'(s1), AW'(s0)};
    flush         = fl;
  endtask

  task automatic idle();
    set_in(1'b0, 0, 0, 3'b000, 0, 0, 0, 1'b0);
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    bit raw, waw, st, acc, tracked;
    int np;
    @(negedge clk);
    np = 0;
    for (int r = 0; r < (1 << AW); r++) if (ready_at[r] > cyc) np++;
    raw = 1'b0;
    for (int k = 0; k < NS; k++)
      if (src_valid[k] && ready_at[src_addr[k*AW +: AW]] > cyc) raw = 1'b1;
    tracked = (issue_latency != 0);
    waw = tracked && (ready_at[issue_dest] > cyc);
    st  = issue_valid && !flush && (raw || waw || (tracked && np == NE));
    acc = issue_valid && !st && !flush;
    chk("stall", 64'(stall_pipeline), 64'(st));
    chk("invalidate", 64'(invalidate), 64'(st));
    chk("full", 64'(full), 64'(np == NE));
    chk("pending", 64'(pending_count), 64'(np));
    chk("stall_count", 64'(stall_count), 64'(sc));
    @(posedge clk);
    if (st && sc != SC_MAX) sc++;
    if (flush) begin
      for (int r = 0; r < (1 << AW); r++) ready_at[r] = 0;
    end else if (acc && tracked) begin
      ready_at[issue_dest] = cyc + longint'(issue_latency) + 1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    cyc = 1;
    #12;
    chk("rst_stall", 64'(stall_pipeline), 64'd0);
    chk("rst_inv", 64'(invalidate), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_pending", 64'(pending_count), 64'd0);
    chk("rst_count", 64'(stall_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Classic load-use: L=1 gives one stall
    set_in(1'b1, 3, 1, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 0, 0, 3'b001, 3, 0, 0, 1'b0); step(); step();
    idle(); step();
    chk("t1_count", 64'(stall_count), 64'd1);

    // L=4 dependant via src1
    set_in(1'b1, 5, 4, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 0, 0, 3'b010, 0, 5, 0, 1'b0);
    repeat (5) step();
    idle(); step();
    chk("t2_count", 64'(stall_count), 64'd5);
    chk("t2_pending", 64'(pending_count), 64'd0);

    // Fill all entries, full stall, then an untracked instruction slips through
    for (int d = 1; d <= 4; d++) begin
      set_in(1'b1, d, 7, 3'b000, 0, 0, 0, 1'b0); step();
    end
    chk("t3_full", 64'(full), 64'd1);
    set_in(1'b1, 6, 2, 3'b000, 0, 0, 0, 1'b0);
    repeat (3) step();
    set_in(1'b1, 0, 0, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 6, 2, 3'b000, 0, 0, 0, 1'b0);
    repeat (6) step();
    idle(); repeat (10) step();

    // WAW on dest 7
    set_in(1'b1, 7, 3, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 7, 1, 3'b000, 0, 0, 0, 1'b0);
    repeat (4) step();
    idle(); repeat (3) step();

    // Flush with a dependant in decode
    set_in(1'b1, 8, 5, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 9, 5, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 10, 2, 3'b001, 8, 0, 0, 1'b1); step();
    idle(); step();
    chk("t5_pending", 64'(pending_count), 64'd0);

    // Drive the stall counter into saturation
    repeat (12) begin
      set_in(1'b1, 11, 7, 3'b000, 0, 0, 0, 1'b0); step();
      set_in(1'b1, 0, 0, 3'b001, 11, 0, 0, 1'b0);
      repeat (8) step();
    end
    idle(); step();
    chk("sat_count", 64'(stall_count), 64'(SC_MAX));

    // Asynchronous reset in the middle of a stall
    set_in(1'b1, 12, 7, 3'b000, 0, 0, 0, 1'b0); step();
    set_in(1'b1, 0, 0, 3'b100, 0, 0, 12, 1'b0); step();
    #2;
    chk("pre_arst_stall", 64'(stall_pipeline), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall_pipeline), 64'd0);
    chk("arst_inv", 64'(invalidate), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_pending", 64'(pending_count), 64'd0);
    chk("arst_count", 64'(stall_count), 64'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with occasional flushes
    repeat (400) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
